// File: rtl/warmboot_sequencer.sv
// warmboot_sequencer
// Hands control from the bootloader to a chosen configuration image.
// The sequence has four steps:
//   1. wait until the SPI flash and the USB transmitter have been quiet for a while
//   2. detach from the host by dropping the D+ pull-up
//   3. let the image select settle
//   4. fire SB_WARMBOOT
// Every output is a register. The counter is shared by all phases and is
// cleared on each phase change.

module warmboot_sequencer #(
    parameter int SPI_IDLE_CYCLES = 16,
    parameter int DETACH_CYCLES   = 12000,
    parameter int SETTLE_CYCLES   = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       boot_req,
    input  logic [1:0] image_sel,
    input  logic       spi_cs_n,
    input  logic       usb_tx_active,
    output logic       usb_pu,
    output logic       usb_tx_inhibit,
    output logic [1:0] warmboot_s,
    output logic       warmboot_boot,
    output logic       busy
);

    localparam int MAX_AB = (SPI_IDLE_CYCLES > DETACH_CYCLES) ? SPI_IDLE_CYCLES : DETACH_CYCLES;
    localparam int MAX_CYCLES = (MAX_AB > SETTLE_CYCLES) ? MAX_AB : SETTLE_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] SPI_LAST    = CNT_W'(SPI_IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DETACH_LAST = CNT_W'(DETACH_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_QUIET,
        DETACH,
        SETTLE,
        BOOT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic             usb_pu_d;
    logic             usb_tx_inhibit_d;
    logic [1:0]       warmboot_s_d;
    logic             warmboot_boot_d;
    logic             busy_d;
    logic             quiet;

    assign quiet = spi_cs_n & ~usb_tx_active;

    // State, counter and all outputs register here; reset takes priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            counter_q      <= '0;
            usb_pu         <= 1'b1;
            usb_tx_inhibit <= 1'b0;
            warmboot_s     <= 2'b01;
            warmboot_boot  <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_d;
            counter_q      <= counter_d;
            usb_pu         <= usb_pu_d;
            usb_tx_inhibit <= usb_tx_inhibit_d;
            warmboot_s     <= warmboot_s_d;
            warmboot_boot  <= warmboot_boot_d;
            busy           <= busy_d;
        end
    end

    // Next-state and next-output logic; by default every register holds its value.
    always_comb begin
        state_d          = state_q;
        counter_d        = counter_q;
        usb_pu_d         = usb_pu;
        usb_tx_inhibit_d = usb_tx_inhibit;
        warmboot_s_d     = warmboot_s;
        warmboot_boot_d  = warmboot_boot;
        busy_d           = busy;

        case (state_q)
            IDLE: begin
                if (boot_req) begin
                    warmboot_s_d = image_sel;
                    busy_d       = 1'b1;
                    counter_d    = '0;
                    state_d      = WAIT_QUIET;
                end
            end
            WAIT_QUIET: begin
                if (quiet && counter_q == SPI_LAST) begin
                    counter_d        = '0;
                    usb_pu_d         = 1'b0;
                    usb_tx_inhibit_d = 1'b1;
                    state_d          = DETACH;
                end else if (quiet) begin
                    counter_d = counter_q + CNT_ONE;
                end else begin
                    counter_d = '0;
                end
            end
            DETACH: begin
                if (counter_q == DETACH_LAST) begin
                    counter_d = '0;
                    state_d   = SETTLE;
                end else begin
                    counter_d = counter_q + CNT_ONE;
                end
            end
            SETTLE: begin
                if (counter_q == SETTLE_LAST) begin
                    counter_d       = '0;
                    warmboot_boot_d = 1'b1;
                    state_d         = BOOT;
                end else begin
                    counter_d = counter_q + CNT_ONE;
                end
            end
            BOOT: begin
                warmboot_boot_d  = 1'b1;
                usb_pu_d         = 1'b0;
                usb_tx_inhibit_d = 1'b1;
                busy_d           = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_warmboot_sequencer.sv
// tb_warmboot_sequencer
// Directed checks of the warmboot sequence using expected edge counts worked
// out by hand. The small instance is built with SPI_IDLE=4, DETACH=10 and
// SETTLE=3. The second instance uses the default parameters.

module tb_warmboot_sequencer;

    logic       clk = 1'b0;
    logic       reset, boot_req, spi_cs_n, usb_tx_active;
    logic [1:0] image_sel;
    logic       usb_pu, usb_tx_inhibit, warmboot_boot, busy;
    logic [1:0] warmboot_s;

    logic       reset_d, boot_req_d;
    logic [1:0] image_sel_d;
    logic       spi_cs_n_d, usb_tx_active_d;
    logic       usb_pu_d, usb_tx_inhibit_d, warmboot_boot_d, busy_d;
    logic [1:0] warmboot_s_d;

    int total_checks = 0;
    int bad_checks   = 0;

    always #5 clk = ~clk;

    warmboot_sequencer #(
        .SPI_IDLE_CYCLES(4),
        .DETACH_CYCLES  (10),
        .SETTLE_CYCLES  (3)
    ) dut_small (
        .clk           (clk),
        .reset         (reset),
        .boot_req      (boot_req),
        .image_sel     (image_sel),
        .spi_cs_n      (spi_cs_n),
        .usb_tx_active (usb_tx_active),
        .usb_pu        (usb_pu),
        .usb_tx_inhibit(usb_tx_inhibit),
        .warmboot_s    (warmboot_s),
        .warmboot_boot (warmboot_boot),
        .busy          (busy)
    );

    warmboot_sequencer dut_default (
        .clk           (clk),
        .reset         (reset_d),
        .boot_req      (boot_req_d),
        .image_sel     (image_sel_d),
        .spi_cs_n      (spi_cs_n_d),
        .usb_tx_active (usb_tx_active_d),
        .usb_pu        (usb_pu_d),
        .usb_tx_inhibit(usb_tx_inhibit_d),
        .warmboot_s    (warmboot_s_d),
        .warmboot_boot (warmboot_boot_d),
        .busy          (busy_d)
    );

    // One active edge, then step away from it before driving or sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        if (observed !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        reset         = 1'b1;
        boot_req      = 1'b0;
        image_sel     = 2'b00;
        spi_cs_n      = 1'b1;
        usb_tx_active = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Issue a request with image 2'b10 just before edge 1, then run 30 edges.
    // Bus activity is applied on edges [start, start+len). A second request
    // with image 2'b11 can be issued at edge req2_edge.
    task automatic applyStimulus(input string name, input int cs_start, input int cs_len,
                                 input int tx_start, input int tx_len, input int req2_edge,
                                 input int exp_fall, input int exp_boot);
        int   fall_edge;
        int   boot_edge;
        logic boot_dropped;
        fall_edge    = 0;
        boot_edge    = 0;
        boot_dropped = 1'b0;
        boot_req     = 1'b1;
        image_sel    = 2'b10;
        for (int e = 1; e <= 30; e++) begin
            tick();
            if (e == 1) begin
                checkOutput({name, "_sel_latched"}, 32'(warmboot_s), 32'd2);
                checkOutput({name, "_busy_set"}, 32'(busy), 32'd1);
            end
            if (fall_edge == 0 && usb_pu == 1'b0) fall_edge = e;
            if (boot_edge == 0 && warmboot_boot == 1'b1) boot_edge = e;
            else if (boot_edge != 0 && warmboot_boot == 1'b0) boot_dropped = 1'b1;
            boot_req      = ((e + 1) == req2_edge);
            image_sel     = ((e + 1) == req2_edge) ? 2'b11 : 2'b00;
            spi_cs_n      = !((e + 1) >= cs_start && (e + 1) < cs_start + cs_len);
            usb_tx_active = ((e + 1) >= tx_start && (e + 1) < tx_start + tx_len);
        end
        checkOutput({name, "_pu_fall_edge"}, 32'(fall_edge), 32'(exp_fall));
        checkOutput({name, "_boot_edge"}, 32'(boot_edge), 32'(exp_boot));
        checkOutput({name, "_boot_held"}, 32'(boot_dropped), 32'd0);
        checkOutput({name, "_sel_frozen"}, 32'(warmboot_s), 32'd2);
        checkOutput({name, "_inhibit_end"}, 32'(usb_tx_inhibit), 32'd1);
        checkOutput({name, "_pu_end"}, 32'(usb_pu), 32'd0);
    endtask

    // Main directed sequence.
    initial begin
        int fall_edge;
        int boot_edge;

        reset_d         = 1'b1;
        boot_req_d      = 1'b0;
        image_sel_d     = 2'b00;
        spi_cs_n_d      = 1'b1;
        usb_tx_active_d = 1'b0;

        // Reset values.
        doReset();
        checkOutput("rst_pu", 32'(usb_pu), 32'd1);
        checkOutput("rst_inhibit", 32'(usb_tx_inhibit), 32'd0);
        checkOutput("rst_sel", 32'(warmboot_s), 32'd1);
        checkOutput("rst_boot", 32'(warmboot_boot), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);

        // When reset and boot_req arrive in the same cycle, reset wins.
        reset     = 1'b1;
        boot_req  = 1'b1;
        image_sel = 2'b11;
        tick();
        checkOutput("rst_vs_req_busy", 32'(busy), 32'd0);
        checkOutput("rst_vs_req_sel", 32'(warmboot_s), 32'd1);

        // Quiet bus: usb_pu falls at edge 5 and warmboot_boot rises at edge 18.
        doReset();
        applyStimulus("quiet", 0, 0, 0, 0, 0, 5, 18);

        // spi_cs_n is low on edges 4..6, so the quiet count restarts and usb_pu falls at edge 10.
        doReset();
        applyStimulus("cs_busy", 4, 3, 0, 0, 0, 10, 23);

        // Bus activity during DETACH (edges 7..8) has no effect on timing.
        doReset();
        applyStimulus("tx_detach", 7, 2, 7, 2, 0, 5, 18);

        // A second request at edge 3 with image 2'b11 is ignored.
        doReset();
        applyStimulus("req_again", 0, 0, 0, 0, 3, 5, 18);

        // Reset while in SETTLE (edges 16..18); reset is taken at edge 17.
        doReset();
        boot_req  = 1'b1;
        image_sel = 2'b10;
        for (int e = 1; e <= 16; e++) begin
            tick();
            boot_req = 1'b0;
        end
        checkOutput("settle_pu_low", 32'(usb_pu), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("mid_rst_pu", 32'(usb_pu), 32'd1);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_boot", 32'(warmboot_boot), 32'd0);
        checkOutput("mid_rst_sel", 32'(warmboot_s), 32'd1);
        checkOutput("mid_rst_inhibit", 32'(usb_tx_inhibit), 32'd0);
        applyStimulus("after_rst", 0, 0, 0, 0, 0, 5, 18);

        // Default parameters: usb_pu falls at edge 17 and boot rises at edge 1+16+12000+12.
        reset_d = 1'b1;
        tick();
        reset_d     = 1'b0;
        boot_req_d  = 1'b1;
        image_sel_d = 2'b11;
        fall_edge   = 0;
        boot_edge   = 0;
        for (int e = 1; e <= 13000; e++) begin
            tick();
            boot_req_d  = 1'b0;
            image_sel_d = 2'b00;
            if (fall_edge == 0 && usb_pu_d == 1'b0) fall_edge = e;
            if (warmboot_boot_d == 1'b1) begin
                boot_edge = e;
                break;
            end
        end
        checkOutput("dflt_pu_fall_edge", 32'(fall_edge), 32'd17);
        checkOutput("dflt_boot_edge", 32'(boot_edge), 32'd12029);
        checkOutput("dflt_sel", 32'(warmboot_s_d), 32'd3);
        checkOutput("dflt_busy", 32'(busy_d), 32'd1);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/warmboot_sequencer.md
Name: warmboot_sequencer

Overview:
- Sequences a clean handoff from the bootloader to a chosen configuration image.
- On a boot request it waits for the SPI flash and the USB transmitter to go quiet, then detaches from the host by dropping the USB pull-up.
- After a settle interval it drives the SB_WARMBOOT image-select and BOOT inputs.
- Sits in the board top between `tinyfpga_bootloader`, the SPI flash pins, the USB pull-up and the SB_WARMBOOT primitive.

Parameters:
- SPI_IDLE_CYCLES, 16: consecutive cycles with the flash deselected and USB TX idle required before detaching (>=1).
- DETACH_CYCLES, 12000: cycles the USB pull-up is held low (1 ms at 12 MHz) (>=1).
- SETTLE_CYCLES, 12: cycles between detach end and BOOT assertion, with image select already stable (>=1).

Ports:
- clk  input  1  block clock, 12 MHz domain.
- reset  input  1  synchronous, active-high.
- boot_req  input  1  single-cycle or level request to warmboot.
- image_sel  input  2  image index, sampled on request acceptance.
- spi_cs_n  input  1  flash chip select as driven to the pin; low means a transaction is in progress.
- usb_tx_active  input  1  USB transmitter output enable.
- usb_pu  output  1  USB D+ pull-up enable.
- usb_tx_inhibit  output  1  forces the USB transmitter off.
- warmboot_s  output  2  to SB_WARMBOOT {S1,S0}.
- warmboot_boot  output  1  to SB_WARMBOOT BOOT.
- busy  output  1  a sequence is in progress.

Behaviour:
- One clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - state IDLE; usb_pu=1; usb_tx_inhibit=0; warmboot_s=2'b01; warmboot_boot=0; busy=0; counter=0.
- Reset wins over every other input, including in the same cycle as boot_req.
- IDLE:
  - If boot_req=1 at an edge: latch image_sel into warmboot_s, set busy=1, clear the counter, go to WAIT_QUIET.
  - Otherwise hold all outputs.
- WAIT_QUIET (quiet = spi_cs_n=1 AND usb_tx_active=0):
  - If quiet and counter == SPI_IDLE_CYCLES-1: go to DETACH, clear the counter, usb_pu<=0, usb_tx_inhibit<=1.
  - Else if quiet: counter+1.
  - Else: counter<=0 (consecutive count restarts).
  - No timeout; the sequence waits indefinitely.
  - With the bus quiet throughout, WAIT_QUIET lasts exactly SPI_IDLE_CYCLES cycles.
- DETACH:
  - usb_pu=0 and usb_tx_inhibit=1 for exactly DETACH_CYCLES cycles.
  - At counter == DETACH_CYCLES-1: go to SETTLE and clear the counter.
  - Activity on spi_cs_n or usb_tx_active is ignored from here on; this is the point of no return.
- SETTLE:
  - Exactly SETTLE_CYCLES cycles; usb_pu stays 0.
  - At end, go to BOOT with warmboot_boot<=1.
- BOOT:
  - Terminal state. warmboot_boot=1, usb_pu=0, usb_tx_inhibit=1, busy=1, held until reset or device reconfiguration.
- boot_req while busy=1: ignored. image_sel changes after acceptance: ignored (warmboot_s frozen).
- Latency from accepted boot_req to warmboot_boot=1 with a quiet bus: 1 + SPI_IDLE_CYCLES + DETACH_CYCLES + SETTLE_CYCLES cycles.
- Counter width: $clog2 of the largest of the three parameters, plus 1. No wrap is possible because each comparison is an equality against parameter-1.
- Reset mid-sequence (any state): next cycle is IDLE with reset values, so usb_pu re-asserts and warmboot_boot drops.

Test Plan:
- Parameters for tests 1-5: SPI_IDLE=4, DETACH=10, SETTLE=3. Quiet bus, boot_req pulse with image_sel=2'b10:
  - warmboot_s=2'b10 one edge after the request.
  - usb_pu falls 5 edges after the request.
  - warmboot_boot rises 18 edges after the request and stays 1.
- spi_cs_n low for 3 cycles starting 2 cycles into WAIT_QUIET:
  - Quiet count restarts; usb_pu falls 4 edges after spi_cs_n returns high.
- usb_tx_active pulsed high during DETACH:
  - No effect; timing is identical to test 1.
- Second boot_req with image_sel=2'b11 during WAIT_QUIET:
  - warmboot_s stays 2'b10; no restart.
- reset asserted in SETTLE:
  - Next edge: usb_pu=1, busy=0, warmboot_boot=0, warmboot_s=2'b01.
  - A fresh request afterwards completes normally.
- Defaults, quiet bus:
  - usb_pu low for exactly 12000 cycles.
  - warmboot_boot asserts at edge 1+16+12000+12.
